// File: rtl/instruction_fetcher.sv
// Owns the PC and fetches 32-bit instructions one byte at a time, assembling them little-endian.
// Latency: 9 cycles per instruction best case; stalls in PUSH while isq_full, freezes on !rdy_in.
// Backpressure: one outstanding byte request; redirect drops stale data via DRAIN.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [7:0]  mem_resp_byte,
  input  logic        isq_full,
  output logic        instruction_ready,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {REQ, WAIT, PUSH, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic [1:0]  byte_cnt;
  logic        req_accept;
  logic        redirect_drain;

  assign req_accept = mem_req_valid && mem_req_ready;

  // A redirect must drain if a request is (or is about to be) outstanding with no response yet.
  assign redirect_drain = ((state == WAIT)  && !mem_resp_valid) ||
                          ((state == REQ)   && req_accept)      ||
                          ((state == DRAIN) && !mem_resp_valid);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state             <= REQ;
      pc                <= RESET_PC;
      buffer            <= 32'h0;
      byte_cnt          <= 2'd0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= 32'h0;
      instruction_ready <= 1'b0;
      instruction_out   <= 32'h0;
      pc_out            <= 32'h0;
    end else if (!rdy_in) begin
      instruction_ready <= 1'b0;
    end else begin
      instruction_ready <= 1'b0;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        byte_cnt <= 2'd0;
        if (redirect_drain) begin
          state         <= DRAIN;
          mem_req_valid <= 1'b0;
        end else begin
          state         <= REQ;
          mem_req_valid <= 1'b1;
          mem_req_addr  <= redirect_pc;
        end
      end else begin
        case (state)
          REQ: begin
            if (req_accept) begin
              state         <= WAIT;
              mem_req_valid <= 1'b0;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pc + {30'b0, byte_cnt};
            end
          end
          WAIT: begin
            if (mem_resp_valid) begin
              buffer[{byte_cnt, 3'b000} +: 8] <= mem_resp_byte;
              if (byte_cnt == 2'd3) begin
                byte_cnt <= 2'd0;
                state    <= PUSH;
              end else begin
                byte_cnt      <= byte_cnt + 2'd1;
                state         <= REQ;
                mem_req_valid <= 1'b1;
                mem_req_addr  <= pc + {30'b0, byte_cnt} + 32'd1;
              end
            end
          end
          PUSH: begin
            if (!isq_full) begin
              instruction_ready <= 1'b1;
              instruction_out   <= buffer;
              pc_out            <= pc;
              pc                <= pc + 32'd4;
              state             <= REQ;
              mem_req_valid     <= 1'b1;
              mem_req_addr      <= pc + 32'd4;
            end
          end
          DRAIN: begin
            if (mem_resp_valid) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pc;
            end
          end
          default: state <= REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a one-outstanding, one-cycle-latency byte memory model.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_byte;
  logic        isq_full;
  logic        instruction_ready;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_bad = 0;
  int nreq  = 0;
  int npush = 0;
  int cycles = 0;
  logic        pend = 1'b0;
  logic [7:0]  pend_byte = 8'h0;
  logic        hold_resp = 1'b0;
  logic [31:0] req_log [0:63];
  logic [31:0] last_pc, last_ins;

  instruction_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_byte(mem_resp_byte),
    .isq_full(isq_full), .instruction_ready(instruction_ready),
    .instruction_out(instruction_out), .pc_out(pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'd0:   b = 8'h13;
      32'd1:   b = 8'h05;
      32'd2:   b = 8'h10;
      32'd3:   b = 8'h00;
      default: b = a[7:0] + 8'h40;
    endcase
    return b;
  endfunction

  // One clock: drive this cycle's response, advance, then observe post-edge outputs.
  task automatic step();
    logic        acc, cons;
    logic [31:0] acc_addr;
    mem_resp_valid = pend && !hold_resp;
    mem_resp_byte  = pend_byte;
    acc      = mem_req_valid && mem_req_ready && rdy_in && rst_in;
    cons     = mem_resp_valid && rdy_in;
    acc_addr = mem_req_addr;
    @(posedge clk_in);
    #1;
    redirect_valid = 1'b0;
    if (cons) pend = 1'b0;
    if (acc) begin
      pend = 1'b1;
      pend_byte = mem_byte(acc_addr);
      req_log[nreq % 64] = acc_addr;
      nreq++;
    end
    if (instruction_ready) begin
      npush++;
      last_pc  = pc_out;
      last_ins = instruction_out;
    end
    cycles++;
  endtask

  task automatic wait_push(input string tag);
    int start;
    start = npush;
    for (int i = 0; i < 40 && npush == start; i++) step();
    check(tag, npush - start, 1);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_byte = 8'h0; isq_full = 1'b0;
    step(); step();
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_ins_rdy", instruction_ready, 0);
    check("rst_ins_out", instruction_out, 0);
    check("rst_pc_out", pc_out, 0);

    // First fetch from reset
    rst_in = 1'b1;
    cycles = 0;
    wait_push("first_push");
    check("first_latency", cycles, 10);
    check("first_req0", req_log[0], 32'h0);
    check("first_req1", req_log[1], 32'h1);
    check("first_req2", req_log[2], 32'h2);
    check("first_req3", req_log[3], 32'h3);
    check("first_ins", last_ins, 32'h0010_0513);
    check("first_pc", last_pc, 32'h0);
    check("next_req_valid", mem_req_valid, 1);
    check("next_req_addr", mem_req_addr, 32'h4);
    step();
    check("pulse_one_cycle", instruction_ready, 0);

    // Queue full: reach PUSH after 7 more cycles, then stall 5
    isq_full = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("full_no_push", npush, 1);
    check("full_req_count", nreq, 8);
    check("full_no_req", mem_req_valid, 0);
    isq_full = 1'b0;
    step();
    check("full_release_pulse", instruction_ready, 1);
    check("full_pc", pc_out, 32'h4);
    check("full_ins", instruction_out, 32'h4746_4544);
    for (int i = 0; i < 3; i++) step();
    check("full_single_push", npush, 2);

    // Redirect while waiting for byte 2 of pc=8
    for (int i = 0; i < 20 && req_log[(nreq + 63) % 64] != 32'hA; i++) step();
    check("mid_reached_byte2", req_log[(nreq + 63) % 64], 32'hA);
    hold_resp = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    check("drain_no_req", mem_req_valid, 0);
    hold_resp = 1'b0;
    step();
    check("drain_next_valid", mem_req_valid, 1);
    check("drain_next_addr", mem_req_addr, 32'h100);
    wait_push("redir_push");
    check("redir_pc", last_pc, 32'h100);
    check("redir_ins", last_ins, 32'h4342_4140);

    // Redirect while stalled in PUSH
    isq_full = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("push_stall_count", npush, 3);
    isq_full = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("push_redir_no_pulse", instruction_ready, 0);
    check("push_redir_valid", mem_req_valid, 1);
    check("push_redir_addr", mem_req_addr, 32'hFFFF_FFFC);
    wait_push("wrap_push");
    check("wrap_pc", last_pc, 32'hFFFF_FFFC);
    check("wrap_ins", last_ins, 32'h3F3E_3D3C);
    check("wrap_next_addr", mem_req_addr, 32'h0);

    // rdy_in low for 3 cycles during WAIT with the response presented
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen_no_pulse", instruction_ready, 0);
    end
    check("frozen_no_req", mem_req_valid, 0);
    check("frozen_req_count", req_log[(nreq + 63) % 64], 32'h0);
    rdy_in = 1'b1;
    wait_push("frozen_push");
    check("frozen_pc", last_pc, 32'h0);
    check("frozen_ins", last_ins, 32'h0010_0513);

    // Reset during WAIT; stale response afterwards must be ignored
    step();
    hold_resp = 1'b1;
    rst_in = 1'b0;
    step();
    check("midrst_req_valid", mem_req_valid, 0);
    check("midrst_req_addr", mem_req_addr, 32'h0);
    check("midrst_ins_rdy", instruction_ready, 0);
    check("midrst_pc_out", pc_out, 32'h0);
    rst_in = 1'b1;
    hold_resp = 1'b0;
    step();
    check("midrst_stale_no_push", instruction_ready, 0);
    check("midrst_next_addr", mem_req_addr, 32'h0);
    check("midrst_next_valid", mem_req_valid, 1);
    wait_push("midrst_push");
    check("midrst_pc", last_pc, 32'h0);
    check("midrst_ins", last_ins, 32'h0010_0513);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
